// File: rtl/div_scheduler_pkg.sv
// Shared types and helpers for the shared-divider scheduler.
package div_scheduler_pkg;

   // Widest operand the sign helpers handle; callers truncate back to their width.
   localparam int unsigned MaxWidth = 64;
   typedef logic [MaxWidth-1:0] wide_t;

   // RISC-V funct3[1:0] encodings of the M-extension divide ops.
   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } op_e;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   function automatic logic is_signed_op(op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_rem_op(op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   // Two's-complement negate when neg is set; correct modulo 2^width after truncation.
   function automatic wide_t cond_neg(wide_t v, logic neg);
      return neg ? (~v + wide_t'(1)) : v;
   endfunction

   // Magnitude of a width-bit two's-complement value held zero-extended in v.
   function automatic wide_t abs_val(wide_t v, int unsigned width);
      return cond_neg(v, v[width-1]);
   endfunction

endpackage

// File: rtl/div_scheduler_divider.sv
// Iterative restoring divider, one quotient bit per cycle, valid/ready result handshake.
module div_scheduler_divider
   import div_scheduler_pkg::*;
#(
   parameter string       SIGNED        = "False",
   parameter int unsigned FRACTION_BITS = 0,
   parameter int unsigned DIV_SIZE      = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   output logic                ready_o,
   input  logic [DIV_SIZE-1:0] dividend,
   input  logic [DIV_SIZE-1:0] divisor,
   output logic                valid,
   input  logic                ready_i,
   output logic [DIV_SIZE-1:0] quotient,
   output logic [DIV_SIZE-1:0] remainder
);

   localparam bit          IsSigned = (SIGNED == "True");
   localparam int unsigned Steps    = DIV_SIZE + FRACTION_BITS;
   localparam int unsigned CntW     = $clog2(Steps + 1);

   logic                busy_q, busy_d, valid_q, valid_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [Steps-1:0]    quo_q, quo_d;
   logic [DIV_SIZE-1:0] rem_q, rem_d, den_q, den_d, a_mag, b_mag;
   logic                negq_q, negq_d, negr_q, negr_d;
   logic [DIV_SIZE:0]   trial, diff;
   logic                ge;

   assign a_mag = IsSigned ? DIV_SIZE'(abs_val(wide_t'(dividend), DIV_SIZE)) : dividend;
   assign b_mag = IsSigned ? DIV_SIZE'(abs_val(wide_t'(divisor), DIV_SIZE)) : divisor;
   assign trial = {rem_q, quo_q[Steps-1]};
   assign diff  = trial - {1'b0, den_q};
   assign ge    = ~diff[DIV_SIZE];

   assign ready_o   = ~busy_q & ~valid_q;
   assign valid     = valid_q;
   assign quotient  = DIV_SIZE'(cond_neg(wide_t'(quo_q[DIV_SIZE-1:0]), negq_q));
   assign remainder = DIV_SIZE'(cond_neg(wide_t'(rem_q), negr_q));

   // Next state: load on start, shift-subtract while busy, hold result until taken.
   always_comb begin
      busy_d  = busy_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      den_d   = den_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      if (start && ready_o) begin
         busy_d = 1'b1;
         cnt_d  = CntW'(Steps);
         quo_d  = Steps'(a_mag) << FRACTION_BITS;
         rem_d  = '0;
         den_d  = b_mag;
         negq_d = IsSigned && (dividend[DIV_SIZE-1] ^ divisor[DIV_SIZE-1]);
         negr_d = IsSigned && dividend[DIV_SIZE-1];
      end else if (busy_q) begin
         quo_d = {quo_q[Steps-2:0], ge};
         rem_d = ge ? diff[DIV_SIZE-1:0] : trial[DIV_SIZE-1:0];
         cnt_d = cnt_q - CntW'(1);
         if (cnt_q == CntW'(1)) begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         den_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         den_q   <= den_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
      end
   end

endmodule

// File: rtl/div_scheduler.sv
// Round-robin scheduler sharing one unsigned divider for DIV/DIVU/REM/REMU.
module div_scheduler
   import div_scheduler_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [2*NUM_REQ-1:0]          req_op,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] req_numerator,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] req_denominator,
   output logic [NUM_REQ-1:0]            resp_valid,
   input  logic [NUM_REQ-1:0]            resp_ready,
   output logic [DATA_WIDTH-1:0]         resp_result
);

   localparam logic [DATA_WIDTH-1:0] MinVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // First valid requester at or after ptr, wrapping; MSB of the result flags a hit.
   function automatic logic [ID_W:0] rr_pick(logic [NUM_REQ-1:0] vld, logic [ID_W-1:0] ptr);
      logic [ID_W:0] r;
      int            idx;
      r = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % int'(NUM_REQ);
         if (vld[idx]) r = {1'b1, ID_W'(idx)};
      end
      return r;
   endfunction

   state_e                state_q, state_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d, id_q, id_d, grant;
   op_e                   op_q, op_d, g_op;
   logic [DATA_WIDTH-1:0] num_q, num_d, den_q, den_d, res_q, res_d;
   logic [DATA_WIDTH-1:0] g_num, g_den, g_res, fixed;
   logic                  found, g_special, q_neg, r_neg;

   logic                  div_start, div_in_ready, div_out_ready, div_valid;
   logic [DATA_WIDTH-1:0] div_a, div_b, div_quotient, div_remainder;

   // Arbitration and special-case detection on the currently granted request.
   always_comb begin
      {found, grant} = rr_pick(req_valid, rr_ptr_q);
      g_op      = op_e'(req_op[2*grant +: 2]);
      g_num     = req_numerator[DATA_WIDTH*grant +: DATA_WIDTH];
      g_den     = req_denominator[DATA_WIDTH*grant +: DATA_WIDTH];
      g_special = 1'b0;
      g_res     = '0;
      if (g_den == '0) begin
         g_special = 1'b1;
         g_res     = is_rem_op(g_op) ? g_num : '1;
      end else if (is_signed_op(g_op) && g_num == MinVal && g_den == '1) begin
         g_special = 1'b1;
         g_res     = is_rem_op(g_op) ? '0 : g_num;
      end
   end

   // The divider only ever sees magnitudes; signs are restored on capture.
   assign div_a = is_signed_op(op_q) ? DATA_WIDTH'(abs_val(wide_t'(num_q), DATA_WIDTH)) : num_q;
   assign div_b = is_signed_op(op_q) ? DATA_WIDTH'(abs_val(wide_t'(den_q), DATA_WIDTH)) : den_q;
   assign q_neg = is_signed_op(op_q) && (num_q[DATA_WIDTH-1] ^ den_q[DATA_WIDTH-1]);
   assign r_neg = is_signed_op(op_q) && num_q[DATA_WIDTH-1];
   assign fixed = is_rem_op(op_q) ? DATA_WIDTH'(cond_neg(wide_t'(div_remainder), r_neg))
                                  : DATA_WIDTH'(cond_neg(wide_t'(div_quotient), q_neg));

   assign resp_result = res_q;

   // FSM next state and handshake outputs; all outputs forced low while in reset.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      id_d          = id_q;
      op_d          = op_q;
      num_d         = num_q;
      den_d         = den_q;
      res_d         = res_q;
      req_ready     = '0;
      resp_valid    = '0;
      div_start     = 1'b0;
      div_out_ready = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               req_ready[grant] = 1'b1;
               id_d  = grant;
               op_d  = g_op;
               num_d = g_num;
               den_d = g_den;
               if (g_special) begin
                  res_d   = g_res;
                  state_d = StResp;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            div_start = div_in_ready;
            if (div_in_ready) state_d = StWait;
         end
         StWait: begin
            div_out_ready = 1'b1;
            if (div_valid) begin
               res_d   = fixed;
               state_d = StResp;
            end
         end
         StResp: begin
            resp_valid[id_q] = 1'b1;
            if (resp_ready[id_q]) begin
               rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (reset) begin
         req_ready     = '0;
         resp_valid    = '0;
         div_start     = 1'b0;
         div_out_ready = 1'b0;
      end
   end

   // State and latched-request registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         id_q     <= '0;
         op_q     <= OP_DIV;
         num_q    <= '0;
         den_q    <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         op_q     <= op_d;
         num_q    <= num_d;
         den_q    <= den_d;
         res_q    <= res_d;
      end
   end

   div_scheduler_divider #(
      .SIGNED       ("False"),
      .FRACTION_BITS(0),
      .DIV_SIZE     (DATA_WIDTH)
   ) u_divider (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .ready_o  (div_in_ready),
      .dividend (div_a),
      .divisor  (div_b),
      .valid    (div_valid),
      .ready_i  (div_out_ready),
      .quotient (div_quotient),
      .remainder(div_remainder)
   );

endmodule

// File: tb/tb_div_scheduler.sv
// Scoreboard bench for div_scheduler with two requesters and 8-bit data.
module tb_div_scheduler;

   localparam int W = 8;
   localparam int N = 2;
   localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
   logic [2*N-1:0] req_op;
   logic [W*N-1:0] req_numerator, req_denominator;
   logic [W-1:0]   resp_result;

   logic           lv[N];
   logic [1:0]     lop[N];
   logic [W-1:0]   lnum[N], lden[N];

   assign req_valid       = {lv[1], lv[0]};
   assign req_op          = {lop[1], lop[0]};
   assign req_numerator   = {lnum[1], lnum[0]};
   assign req_denominator = {lden[1], lden[0]};

   always #5 clock = ~clock;

   div_scheduler #(
      .DATA_WIDTH(W),
      .NUM_REQ   (N)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_op         (req_op),
      .req_numerator  (req_numerator),
      .req_denominator(req_denominator),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_result    (resp_result)
   );

   typedef struct {int lane; logic [1:0] op; logic [W-1:0] n; logic [W-1:0] d;
                   logic [W-1:0] res; bit special;} op_t;
   typedef struct {int lane; logic [W-1:0] res; int acc; bit special;} exp_t;

   op_t ops [16] = '{
      '{0, DIV,  8'hE3, 8'h0A, 8'hFE, 1'b0},   // -29 / 10
      '{0, REM,  8'hE3, 8'h0A, 8'hF7, 1'b0},   // -29 % 10
      '{0, DIVU, 8'hE3, 8'h0A, 8'h16, 1'b0},   // 227 / 10
      '{0, REM,  8'h1D, 8'hF6, 8'h09, 1'b0},   // 29 % -10
      '{1, DIV,  8'h01, 8'h00, 8'hFF, 1'b1},   // divide by zero
      '{1, REMU, 8'h01, 8'h00, 8'h01, 1'b1},
      '{0, DIV,  8'h80, 8'hFF, 8'h80, 1'b1},   // signed overflow
      '{0, REM,  8'h80, 8'hFF, 8'h00, 1'b1},
      '{0, DIV,  8'h64, 8'h07, 8'h0E, 1'b0},   // 100 / 7
      '{0, REMU, 8'hC8, 8'h0D, 8'h05, 1'b0},   // 200 % 13
      '{1, DIVU, 8'hFF, 8'h10, 8'h0F, 1'b0},   // 255 / 16
      '{1, REM,  8'h9C, 8'h07, 8'hFE, 1'b0},   // -100 % 7
      '{1, DIVU, 8'h50, 8'h03, 8'h1A, 1'b0},   // 80 / 3
      '{0, DIV,  8'h1D, 8'h0A, 8'h02, 1'b0},   // 29 / 10
      '{1, REMU, 8'h2B, 8'h05, 8'h03, 1'b0},   // 43 % 5
      '{0, DIVU, 8'h07, 8'h00, 8'hFF, 1'b1}
   };

   exp_t sb[$];
   int   grant_log[$];
   int   grant_cyc[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   start_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) if (dut.div_start) start_cnt <= start_cnt + 1;

   // Pop and compare on every response handshake; any response with nothing pending is an error.
   always @(negedge clock) begin
      if (!reset && resp_valid != '0) begin
         if (sb.size() == 0) begin
            check_val("spurious_resp", 32'(resp_valid), 0);
         end else if ((resp_valid & resp_ready) != '0) begin
            exp_t e;
            e = sb.pop_front();
            check_val("resp_lane", 32'(resp_valid), 1 << e.lane);
            check_val("resp_result", 32'(resp_result), 32'(e.res));
            if (e.special) check_val("special_latency", cyc - e.acc, 1);
         end
      end
   end

   // Present ops first..first+count-1 on one lane back to back; push expectations on accept.
   task automatic lane_run(input int lane, input int first, input int count);
      for (int k = 0; k < count; k++) begin
         int idx = first + k;
         int t   = 0;
         lv[lane]   = 1'b1;
         lop[lane]  = ops[idx].op;
         lnum[lane] = ops[idx].n;
         lden[lane] = ops[idx].d;
         do begin
            @(negedge clock);
            t++;
         end while (!req_ready[lane] && t < 60);
         check_val("grant", 32'(req_ready[lane]), 1);
         if (req_ready[lane]) begin
            sb.push_back(exp_t'{lane, ops[idx].res, cyc, ops[idx].special});
            grant_log.push_back(lane);
            grant_cyc.push_back(cyc);
         end
         @(posedge clock);
         #1;
         lv[lane]   = 1'b0;
         lop[lane]  = 2'($urandom);
         lnum[lane] = 8'($urandom);
         lden[lane] = 8'($urandom);
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb.size() != 0 && t < 80) begin
         @(negedge clock);
         t++;
      end
      check_val("drain", sb.size(), 0);
      @(posedge clock);
      #1;
   endtask

   task automatic run_single(input int idx);
      int s0 = start_cnt;
      lane_run(ops[idx].lane, idx, 1);
      wait_drain();
      check_val("div_starts", start_cnt - s0, ops[idx].special ? 0 : 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0;
      int t;
      int rel_cyc;
      for (int i = 0; i < N; i++) begin
         lv[i] = 1'b0; lop[i] = '0; lnum[i] = '0; lden[i] = '0;
      end
      resp_ready = '1;

      // Reset with a request pending: nothing may be accepted or answered.
      lv[0] = 1'b1; lop[0] = ops[13].op; lnum[0] = ops[13].n; lden[0] = ops[13].d;
      repeat (2) begin
         @(negedge clock);
         check_val("rst_req_ready", 32'(req_ready), 0);
         check_val("rst_resp_valid", 32'(resp_valid), 0);
      end
      @(posedge clock);
      #1;
      lv[0] = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      check_val("init_resp_valid", 32'(resp_valid), 0);
      check_val("init_resp_result", 32'(resp_result), 0);
      check_val("init_div_start", 32'(dut.div_start), 0);
      @(posedge clock);
      #1;

      // Both lanes continuously valid from reset: grants alternate starting with lane 0.
      grant_log.delete();
      fork
         lane_run(0, 8, 2);
         lane_run(1, 10, 2);
      join
      wait_drain();
      for (int i = 0; i < 4; i++)
         check_val("rr_order", grant_log.size() > i ? grant_log[i] : -1, i % 2);

      // Directed signed/unsigned and special-case ops.
      for (int i = 0; i < 8; i++) run_single(i);

      // Stall in RESP for 5 cycles with a competing request on lane 0.
      resp_ready[1] = 1'b0;
      s0 = start_cnt;
      lane_run(1, 12, 1);
      t = 0;
      while (!resp_valid[1] && t < 40) begin
         @(negedge clock);
         t++;
      end
      check_val("stall_arrive", 32'(resp_valid[1]), 1);
      lv[0] = 1'b1; lop[0] = ops[15].op; lnum[0] = ops[15].n; lden[0] = ops[15].d;
      repeat (5) begin
         @(negedge clock);
         check_val("stall_resp_valid", 32'(resp_valid), 32'h2);
         check_val("stall_resp_result", 32'(resp_result), 32'h1A);
         check_val("stall_req_ready", 32'(req_ready), 0);
         check_val("stall_starts", start_cnt - s0, 1);
      end
      @(posedge clock);
      #1;
      resp_ready[1] = 1'b1;
      lane_run(0, 15, 1);
      wait_drain();

      // Reset while the divider is busy: the op vanishes and lane 0 wins the next grant.
      s0 = start_cnt;
      lv[1] = 1'b1; lop[1] = ops[12].op; lnum[1] = ops[12].n; lden[1] = ops[12].d;
      t = 0;
      do begin
         @(negedge clock);
         t++;
      end while (!req_ready[1] && t < 40);
      check_val("abort_grant", 32'(req_ready[1]), 1);
      @(posedge clock);
      #1;
      lv[1] = 1'b0;
      t = 0;
      while (start_cnt == s0 && t < 40) begin
         @(negedge clock);
         t++;
      end
      check_val("abort_started", start_cnt - s0, 1);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      lv[0] = 1'b1; lop[0] = ops[13].op; lnum[0] = ops[13].n; lden[0] = ops[13].d;
      lv[1] = 1'b1; lop[1] = ops[14].op; lnum[1] = ops[14].n; lden[1] = ops[14].d;
      @(negedge clock);
      check_val("midrst_req_ready", 32'(req_ready), 0);
      check_val("midrst_resp_valid", 32'(resp_valid), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      rel_cyc = cyc;
      grant_log.delete();
      grant_cyc.delete();
      fork
         lane_run(0, 13, 1);
         lane_run(1, 14, 1);
      join
      wait_drain();
      check_val("post_rst_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);
      check_val("post_rst_idle", grant_cyc.size() > 0 ? grant_cyc[0] : -1, rel_cyc);

      repeat (20) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
